// File: rtl/key_pulse_stretcher.sv
// Per-channel press regenerator: each accepted p_key pulse becomes a fixed-width
// key pulse followed by a guaranteed low gap. Optional feature macro: KEY_STRETCH_PENDING_EN.
module key_pulse_stretcher #(
    parameter int NUM_KEYS    = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] p_key,
    output logic [NUM_KEYS-1:0] key,
    output logic [NUM_KEYS-1:0] busy,
    output logic [NUM_KEYS-1:0] overrun
);

    localparam int unsigned MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state_q [NUM_KEYS];
    state_t        state_d [NUM_KEYS];
    logic [CW-1:0] cnt_q   [NUM_KEYS];
    logic [CW-1:0] cnt_d   [NUM_KEYS];

    logic [NUM_KEYS-1:0] key_d;
    logic [NUM_KEYS-1:0] busy_d;
    logic [NUM_KEYS-1:0] overrun_d;

`ifdef KEY_STRETCH_PENDING_EN
    logic [NUM_KEYS-1:0] pend_q;
    logic [NUM_KEYS-1:0] pend_d;
`endif

    always_comb begin
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            overrun_d[i] = 1'b0;
`ifdef KEY_STRETCH_PENDING_EN
            pend_d[i]    = pend_q[i];
`endif
            unique case (state_q[i])
                IDLE: begin
                    if (p_key[i]) begin
                        state_d[i] = HOLD;
                        cnt_d[i]   = HOLD_LOAD;
                    end
                end
                HOLD, GAP: begin
                    if (state_q[i] == GAP && cnt_q[i] == '0) begin
                        // Final gap cycle: a stored press wins and a fresh pulse
                        // becomes the new stored press; otherwise the pulse is
                        // accepted exactly as it would be in IDLE.
`ifdef KEY_STRETCH_PENDING_EN
                        if (pend_q[i]) begin
                            state_d[i] = HOLD;
                            cnt_d[i]   = HOLD_LOAD;
                            pend_d[i]  = p_key[i];
                        end else
`endif
                        if (p_key[i]) begin
                            state_d[i] = HOLD;
                            cnt_d[i]   = HOLD_LOAD;
                        end else begin
                            state_d[i] = IDLE;
                        end
                    end else begin
                        if (cnt_q[i] == '0) begin
                            state_d[i] = GAP;
                            cnt_d[i]   = GAP_LOAD;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CW'(1);
                        end
`ifdef KEY_STRETCH_PENDING_EN
                        if (p_key[i]) begin
                            if (!pend_q[i]) pend_d[i] = 1'b1;
                            else            overrun_d[i] = 1'b1;
                        end
`else
                        overrun_d[i] = p_key[i];
`endif
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
            key_d[i]  = (state_d[i] == HOLD);
            busy_d[i] = (state_d[i] != IDLE);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            key     <= '0;
            busy    <= '0;
            overrun <= '0;
`ifdef KEY_STRETCH_PENDING_EN
            pend_q  <= '0;
`endif
        end else begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            key     <= key_d;
            busy    <= busy_d;
            overrun <= overrun_d;
`ifdef KEY_STRETCH_PENDING_EN
            pend_q  <= pend_d;
`endif
        end
    end

endmodule

// File: tb/tb_key_pulse_stretcher.sv
// Bench for key_pulse_stretcher: default instance plus a HOLD=1/GAP=1 instance,
// both compared every cycle against a press-start-time reference model.
module tb_key_pulse_stretcher;

`ifdef KEY_STRETCH_PENDING_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] p_key0, p_key1;
    logic [3:0] key0, busy0, overrun0;
    logic [3:0] key1, busy1, overrun1;

    always #5 clock = ~clock;

    key_pulse_stretcher #(.NUM_KEYS(4), .HOLD_CYCLES(8), .GAP_CYCLES(2)) dut0 (
        .clock(clock), .reset(reset), .p_key(p_key0),
        .key(key0), .busy(busy0), .overrun(overrun0)
    );

    key_pulse_stretcher #(.NUM_KEYS(4), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut1 (
        .clock(clock), .reset(reset), .p_key(p_key1),
        .key(key1), .busy(busy1), .overrun(overrun1)
    );

    int checks = 0;
    int errors = 0;
    longint edge_n = 0;

    // Reference: per channel, the edge at which the current press was accepted
    // and whether one more press is queued behind it.
    longint hold_len [2] = '{8, 1};
    longint gap_len  [2] = '{2, 1};
    longint start    [2][4];
    bit     pend     [2][4];
    logic [3:0] exp_key [2];
    logic [3:0] exp_busy[2];
    logic [3:0] exp_ovr [2];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h, expected %h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic model_edge(input int d, input logic r, input logic [3:0] pk);
        longint s = edge_n;
        for (int ch = 0; ch < 4; ch++) begin
            exp_ovr[d][ch] = 1'b0;
            if (r) begin
                start[d][ch] = -1000;
                pend[d][ch]  = 1'b0;
            end else begin
                if (pend[d][ch] && s == start[d][ch] + hold_len[d] + gap_len[d]) begin
                    start[d][ch] = s;
                    pend[d][ch]  = 1'b0;
                end
                if (pk[ch]) begin
                    if (s >= start[d][ch] + hold_len[d] + gap_len[d]) start[d][ch] = s;
                    else if (PEND && !pend[d][ch])                     pend[d][ch]  = 1'b1;
                    else                                              exp_ovr[d][ch] = 1'b1;
                end
            end
            exp_key[d][ch]  = (s >= start[d][ch]) && (s < start[d][ch] + hold_len[d]);
            exp_busy[d][ch] = (s >= start[d][ch]) && (s < start[d][ch] + hold_len[d] + gap_len[d]);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] pk0, input logic [3:0] pk1);
        @(negedge clock);
        reset  = r;
        p_key0 = pk0;
        p_key1 = pk1;
        @(posedge clock);
        edge_n++;
        model_edge(0, r, pk0);
        model_edge(1, r, pk1);
        #1;
        check_val("d0_key",     {28'b0, key0},     {28'b0, exp_key[0]});
        check_val("d0_busy",    {28'b0, busy0},    {28'b0, exp_busy[0]});
        check_val("d0_overrun", {28'b0, overrun0}, {28'b0, exp_ovr[0]});
        check_val("d1_key",     {28'b0, key1},     {28'b0, exp_key[1]});
        check_val("d1_busy",    {28'b0, busy1},    {28'b0, exp_busy[1]});
        check_val("d1_overrun", {28'b0, overrun1}, {28'b0, exp_ovr[1]});
    endtask

    int k_hi, b_hi, other_hi, ovr_cnt, rise_cnt;
    logic prev;

    initial begin
        reset  = 1'b1;
        p_key0 = '0;
        p_key1 = '0;
        for (int d = 0; d < 2; d++)
            for (int ch = 0; ch < 4; ch++) begin
                start[d][ch] = -1000;
                pend[d][ch]  = 1'b0;
            end

        step(1'b1, 4'b0000, 4'b0000);
        step(1'b1, 4'b0000, 4'b0000);
        check_val("reset_key",  {28'b0, key0},  32'd0);
        check_val("reset_busy", {28'b0, busy0}, 32'd0);

        // Single press on channel 0: 8 high, busy 10, nothing elsewhere.
        k_hi = 0; b_hi = 0; other_hi = 0;
        step(1'b0, 4'b0001, 4'b0000);
        k_hi += key0[0]; b_hi += busy0[0]; other_hi += int'(|{key0[3:1], busy0[3:1]});
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 4'b0000, 4'b0000);
            k_hi += key0[0]; b_hi += busy0[0]; other_hi += int'(|{key0[3:1], busy0[3:1]});
        end
        check_val("single_key_len",  k_hi, 32'd8);
        check_val("single_busy_len", b_hi, 32'd10);
        check_val("single_others",   other_hi, 32'd0);

        // Channels 1 and 3 together.
        step(1'b0, 4'b1010, 4'b0000);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 4'b0000, 4'b0000);
            check_val("pair_same", {31'b0, key0[3]}, {31'b0, key0[1]});
        end

        // Second pulse at HOLD cycle 3 of channel 0.
        rise_cnt = 0; ovr_cnt = 0; prev = 1'b0;
        step(1'b0, 4'b0001, 4'b0000);
        rise_cnt += int'(key0[0] & ~prev); prev = key0[0]; ovr_cnt += overrun0[0];
        for (int i = 0; i < 26; i++) begin
            step(1'b0, (i == 1) ? 4'b0001 : 4'b0000, 4'b0000);
            rise_cnt += int'(key0[0] & ~prev); prev = key0[0]; ovr_cnt += overrun0[0];
        end
        check_val("second_presses", rise_cnt, PEND ? 32'd2 : 32'd1);
        check_val("second_overrun", ovr_cnt,  PEND ? 32'd0 : 32'd1);

        // Three pulses on channel 2 within one HOLD.
        rise_cnt = 0; ovr_cnt = 0; prev = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step(1'b0, (i == 0 || i == 2 || i == 4) ? 4'b0100 : 4'b0000, 4'b0000);
            rise_cnt += int'(key0[2] & ~prev); prev = key0[2]; ovr_cnt += overrun0[2];
        end
        check_val("triple_presses", rise_cnt, PEND ? 32'd2 : 32'd1);
        check_val("triple_overrun", ovr_cnt,  PEND ? 32'd1 : 32'd2);

        // Reset in HOLD cycle 4, then a fresh full press.
        step(1'b0, 4'b0001, 4'b0000);
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0000, 4'b0000);
        step(1'b1, 4'b0001, 4'b0000);
        check_val("midreset_key",  {31'b0, key0[0]},  32'd0);
        check_val("midreset_busy", {31'b0, busy0[0]}, 32'd0);
        step(1'b0, 4'b0000, 4'b0000);
        k_hi = 0;
        step(1'b0, 4'b0001, 4'b0000);
        k_hi += key0[0];
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 4'b0000, 4'b0000);
            k_hi += key0[0];
        end
        check_val("after_reset_len", k_hi, 32'd8);

        // HOLD=1/GAP=1: alternate-cycle pulses toggle key with no overrun.
        ovr_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 4'b0000, (i % 2 == 0) ? 4'b1111 : 4'b0000);
            check_val("alt_toggle", {28'b0, key1}, (i % 2 == 0) ? 32'hF : 32'h0);
            ovr_cnt += int'(|overrun1);
        end
        check_val("alt_overrun", ovr_cnt, 32'd0);

        // Random traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] a, b;
            for (int ch = 0; ch < 4; ch++) begin
                a[ch] = ($urandom_range(0, 5) == 0);
                b[ch] = ($urandom_range(0, 2) == 0);
            end
            step(($urandom_range(0, 199) == 0), a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_pulse_stretcher.md
KEY_PULSE_STRETCHER -- requirements
Module: key_pulse_stretcher

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4, the number of independent key channels (1..32).
REQ-002 SHALL have parameter HOLD_CYCLES, default 8, the high time of each regenerated press in clocks (>=1).
REQ-003 SHALL have parameter GAP_CYCLES, default 2, the minimum low time after each press in clocks (>=1).
REQ-004 SHALL have port clock  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1  the reset, synchronous and active-high.
REQ-006 SHALL have port p_key  input  NUM_KEYS  one-cycle press pulses, one bit per channel.
REQ-007 SHALL have port key  output  NUM_KEYS  regenerated level key signals, registered.
REQ-008 SHALL have port busy  output  NUM_KEYS  per-channel flag, high while the channel is not IDLE.
REQ-009 SHALL have port overrun  output  NUM_KEYS  one-cycle per-channel pulse when a press is discarded, registered.

Function
REQ-010 SHALL run an independent three-state FSM per channel: IDLE, HOLD, GAP.
REQ-011 SHALL give each channel a down-counter of width clog2(max(HOLD_CYCLES,GAP_CYCLES)+1) bits, with no wrap below zero.
REQ-012 SHALL, for a p_key bit high at edge t while IDLE, enter HOLD and drive key high from cycle t+1 for exactly HOLD_CYCLES cycles.
REQ-013 SHALL, at the end of HOLD, enter GAP and drive key low for exactly GAP_CYCLES cycles, then return to IDLE.
REQ-014 SHALL drive key high only in HOLD and busy high in HOLD and GAP, so a downstream rising-edge detector recovers exactly one pulse per regenerated press.
REQ-015 SHALL treat a p_key bit held high across several cycles as one press per cycle it is sampled; sampling follows REQ-012 and REQ-018/019.
REQ-016 SHALL give the GAP-to-IDLE transition and a new p_key in that same cycle the following precedence: the press is accepted as in IDLE, and key rises on the next cycle.
REQ-017 SHALL keep channels fully independent; simultaneous pulses on several bits SHALL each start their own press in the same cycle.
REQ-018 SHALL, for a p_key pulse arriving during HOLD or GAP, behave as given in Configuration.
REQ-019 SHALL pulse overrun for exactly one cycle, the cycle after a discarded press is sampled.

Reset
REQ-020 SHALL, while reset is high at a clock edge, force every channel to IDLE, all counters to 0, key=0, busy=0, overrun=0, and clear any pending flag.
REQ-021 SHALL let reset asserted mid-HOLD drop key low on the next edge with no GAP phase, and SHALL ignore p_key sampled in the same cycle as reset.
REQ-022 SHALL accept p_key normally on the first edge after reset deasserts.

Configuration
REQ-023 SHALL support macro KEY_STRETCH_PENDING_EN.
REQ-024 SHALL, with KEY_STRETCH_PENDING_EN defined, store one pending press per channel for a pulse arriving during HOLD or GAP; at the end of GAP the channel enters HOLD directly, not IDLE, key rises the next cycle, and the pending flag clears.
REQ-025 SHALL, with KEY_STRETCH_PENDING_EN defined and the pending flag already set, discard a further pulse and pulse overrun.
REQ-026 SHALL, without KEY_STRETCH_PENDING_EN, discard every pulse arriving during HOLD or GAP, pulse overrun for it, and synthesise no pending storage.

Verification
REQ-027 SHALL cover: reset, then p_key=4'b0001 for 1 cycle -> key[0] high 8 cycles starting the next cycle, low 2 cycles, busy[0] high 10 cycles, other bits 0.
REQ-028 SHALL cover: p_key=4'b1010 in one cycle -> key[3] and key[1] rise on the same edge and fall on the same edge.
REQ-029 SHALL cover: with PENDING_EN, a second pulse on bit 0 at HOLD cycle 3 -> second 8-cycle press starts right after the 2-cycle gap, overrun stays 0; without PENDING_EN -> a single press and one overrun[0] pulse.
REQ-030 SHALL cover: with PENDING_EN, three pulses on bit 2 within one HOLD -> exactly two presses and exactly one overrun[2] pulse.
REQ-031 SHALL cover: reset asserted in HOLD cycle 4 -> key=0, busy=0 on the next edge, and a pulse 1 cycle after reset deasserts gives a full 8-cycle press.
REQ-032 SHALL cover: with HOLD_CYCLES=1 and GAP_CYCLES=1, pulses on alternate cycles -> key toggles 1,0,1,0 with no overrun.
